fm_freq_word_loader: RTL and testbench



---
 rtl/fm_freq_word_loader.sv | 135 +++++++++++++
 tb/tb_fm_freq_word_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fm_freq_word_loader.sv
// fm_freq_word_loader
// Assembles 48-bit FM frequency tuning words from the host byte link and
// writes them into the FM frequency value register.
//
// Frame: HEADER, 6 payload bytes MSB first, XOR of the 6 payload bytes.
//
// Ports
//   Clock      system clock, rising edge
//   Reset      synchronous, active-low
//   Rx_Data    received byte
//   Rx_Valid   Rx_Data is valid
//   Rx_Ready   loader can accept a byte (registered)
//   Freq_Word  last committed frequency word (register data input)
//   Freq_EN    one-cycle load strobe (register enable)
//   Busy       frame in progress
//   Err        one-cycle pulse on checksum failure or inter-byte timeout
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | hunting for HEADER; non-header bytes are dropped silently
// PAYLOAD | shifting in the 6 payload bytes, running XOR checksum
// CHECK   | waiting for the checksum byte
// COMMIT  | Freq_EN high for this one cycle; Rx_Ready held low

module fm_freq_word_loader #(
  parameter logic [7:0] HEADER         = 8'hF5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_Valid,
  output logic        Rx_Ready,
  output logic [47:0] Freq_Word,
  output logic        Freq_EN,
  output logic        Busy,
  output logic        Err
);

  localparam int            CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, COMMIT} state_t;

  state_t        state, state_nxt;
  logic [47:0]   shadow;
  logic [7:0]    chk;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;

  logic accept, in_frame, expired;
  logic start, take, load, fail;

  assign accept   = Rx_Valid && Rx_Ready;
  assign in_frame = (state == PAYLOAD) || (state == CHECK);
  // An accept on the expiry edge wins, so expiry requires no accept.
  assign expired  = in_frame && (cnt == CNT_LAST) && !accept;
  assign Busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    take      = 1'b0;
    load      = 1'b0;
    fail      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && (Rx_Data == HEADER)) begin
          start     = 1'b1;
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          take = 1'b1;
          if (idx == 3'd5) state_nxt = CHECK;
        end else if (expired) begin
          fail      = 1'b1;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (accept) begin
          if (Rx_Data == chk) begin
            load      = 1'b1;
            state_nxt = COMMIT;
          end else begin
            fail      = 1'b1;
            state_nxt = IDLE;
          end
        end else if (expired) begin
          fail      = 1'b1;
          state_nxt = IDLE;
        end
      end
      COMMIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= IDLE;
      Rx_Ready  <= 1'b0;
      Freq_Word <= 48'h0;
      Freq_EN   <= 1'b0;
      Err       <= 1'b0;
      shadow    <= 48'h0;
      chk       <= 8'h0;
      idx       <= 3'd0;
      cnt       <= '0;
    end else begin
      state    <= state_nxt;
      Rx_Ready <= (state_nxt != COMMIT);
      Freq_EN  <= load;
      Err      <= fail;
      if (load) Freq_Word <= shadow;

      if (start || fail) begin
        shadow <= 48'h0;
        chk    <= 8'h0;
        idx    <= 3'd0;
      end else if (take) begin
        shadow <= {shadow[39:0], Rx_Data};
        chk    <= chk ^ Rx_Data;
        idx    <= idx + 3'd1;
      end

      // Counts idle cycles inside a frame; any accept or leaving the frame clears it.
      if (in_frame && !accept && !expired) cnt <= cnt + CW'(1);
      else                                 cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fm_freq_word_loader.sv
module tb_fm_freq_word_loader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  Rx_Data;
  logic        Rx_Valid;
  logic        Rx_Ready;
  logic [47:0] Freq_Word;
  logic        Freq_EN;
  logic        Busy;
  logic        Err;

  fm_freq_word_loader #(.HEADER(8'hF5), .TIMEOUT_CYCLES(16)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Rx_Data   (Rx_Data),
    .Rx_Valid  (Rx_Valid),
    .Rx_Ready  (Rx_Ready),
    .Freq_Word (Freq_Word),
    .Freq_EN   (Freq_EN),
    .Busy      (Busy),
    .Err       (Err)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc      = 0;
  int en_cnt   = 0;
  int err_cnt  = 0;
  int rdy_low  = 0;
  int en_edge  = 0;
  int both     = 0;
  logic [47:0] words[$];

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    if (Freq_EN) begin
      en_cnt++;
      en_edge = cyc;
      words.push_back(Freq_Word);
    end
    if (Err) err_cnt++;
    if (Freq_EN && Err) both++;
    if (!Rx_Ready) rdy_low++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents a byte and holds Rx_Valid until it is accepted; returns the
  // cycle number of the accepting edge.
  task automatic send(input logic [7:0] b, output int acc);
    logic ok;
    int   n;
    Rx_Data  = b;
    Rx_Valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    do begin
      @(negedge Clock);
      ok = Rx_Ready;
      @(posedge Clock);
      #1;
      n++;
    end while (!ok && n < 20);
    if (!ok) check("send_accept", 0, 1);
    acc = cyc;
  endtask

  task automatic idle(input int n);
    Rx_Valid = 1'b0;
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send_frame(input logic [47:0] w, input logic [7:0] c, output int hdr);
    int a;
    send(8'hF5, hdr);
    for (int i = 5; i >= 0; i--) send(w[i*8 +: 8], a);
    send(c, a);
  endtask

  int hdr, hdr2, a, en0, err0, rdy0;

  initial begin
    Reset    = 1'b0;
    Rx_Data  = 8'h00;
    Rx_Valid = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_word",  Freq_Word, 48'h0);
    check("rst_en",    Freq_EN,   0);
    check("rst_err",   Err,       0);
    check("rst_ready", Rx_Ready,  0);
    check("rst_busy",  Busy,      0);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check("ready_after_rst", Rx_Ready, 1);

    // Good frame, valid continuous
    en0 = en_cnt; err0 = err_cnt;
    send_frame(48'h123456789ABC, 8'h2E, hdr);
    idle(3);
    check("good_word",   Freq_Word, 48'h123456789ABC);
    check("good_en_cnt", en_cnt - en0, 1);
    check("good_en_lat", en_edge - hdr, 7);
    check("good_err",    err_cnt - err0, 0);

    // Bad checksum
    en0 = en_cnt; err0 = err_cnt;
    send_frame(48'h123456789ABC, 8'h2F, hdr);
    #2;
    check("bad_err_now", Err, 1);
    idle(3);
    check("bad_err_cnt", err_cnt - err0, 1);
    check("bad_en_cnt",  en_cnt - en0, 0);
    check("bad_word",    Freq_Word, 48'h123456789ABC);
    check("bad_busy",    Busy, 0);

    // Garbage then resync; a header byte inside the payload is data
    en0 = en_cnt; err0 = err_cnt;
    send(8'h00, a); send(8'hAA, a);
    send_frame(48'h000000000001, 8'h01, hdr);
    idle(3);
    check("resync_word", Freq_Word, 48'h000000000001);
    check("resync_en",   en_cnt - en0, 1);
    check("resync_err",  err_cnt - err0, 0);
    en0 = en_cnt;
    send_frame(48'hF5F5F5F5F5F5, 8'h00, hdr);
    idle(3);
    check("hdr_as_data_word", Freq_Word, 48'hF5F5F5F5F5F5);
    check("hdr_as_data_en",   en_cnt - en0, 1);

    // Timeout: 16 idle cycles expire, 15 do not
    err0 = err_cnt; en0 = en_cnt;
    send(8'hF5, a); send(8'h12, a); send(8'h34, a);
    idle(15);
    check("to_busy_15", Busy, 1);
    check("to_err_15",  Err, 0);
    idle(1);
    check("to_err_16",  Err, 1);
    check("to_busy_16", Busy, 0);
    idle(2);
    check("to_err_cnt", err_cnt - err0, 1);
    err0 = err_cnt;
    send_frame(48'hA1B2C3D4E5F6, 8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4 ^ 8'hE5 ^ 8'hF6, hdr);
    idle(3);
    check("to_after_word", Freq_Word, 48'hA1B2C3D4E5F6);
    check("to_after_en",   en_cnt - en0, 1);
    en0 = en_cnt;
    send(8'hF5, a); send(8'h12, a); send(8'h34, a);
    idle(15);
    send(8'h56, a); send(8'h78, a); send(8'h9A, a); send(8'hBC, a); send(8'h2E, a);
    idle(3);
    check("gap15_err",  err_cnt - err0, 0);
    check("gap15_en",   en_cnt - en0, 1);
    check("gap15_word", Freq_Word, 48'h123456789ABC);

    // Back-to-back frames with Rx_Valid held
    en0 = en_cnt; rdy0 = rdy_low;
    words.delete();
    send_frame(48'h123456789ABC, 8'h2E, hdr);
    send_frame(48'h010203040506, 8'h07, hdr2);
    idle(3);
    check("b2b_en",     en_cnt - en0, 2);
    check("b2b_rdylow", rdy_low - rdy0, 2);
    check("b2b_period", hdr2 - hdr, 9);
    check("b2b_nwords", words.size(), 2);
    if (words.size() == 2) begin
      check("b2b_word0", words[0], 48'h123456789ABC);
      check("b2b_word1", words[1], 48'h010203040506);
    end

    // Reset mid-frame
    en0 = en_cnt; err0 = err_cnt;
    send(8'hF5, a); send(8'h11, a); send(8'h22, a); send(8'h33, a);
    Rx_Valid = 1'b0;
    Reset    = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    check("mid_rst_word",  Freq_Word, 48'h0);
    check("mid_rst_busy",  Busy, 0);
    check("mid_rst_ready", Rx_Ready, 0);
    check("mid_rst_en",    Freq_EN, 0);
    check("mid_rst_err",   Err, 0);
    send(8'h44, a); send(8'h55, a); send(8'h66, a); send(8'h77, a);
    idle(3);
    check("mid_rest_word", Freq_Word, 48'h0);
    check("mid_rest_busy", Busy, 0);
    check("mid_rest_en",   en_cnt - en0, 0);
    check("mid_rest_err",  err_cnt - err0, 0);
    send_frame(48'h010203040506, 8'h07, hdr);
    idle(3);
    check("mid_new_word", Freq_Word, 48'h010203040506);
    check("mid_new_en",   en_cnt - en0, 1);

    check("en_err_overlap", both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
